// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: framer state encoding and the
//               parity-mode names accepted by the RX deframer / TX framer.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Frame engine states; explicit 3-bit encoding shared by RX and TX
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_e;

  // Legal values of the PARITY parameter
  localparam string c_parity_none = "none";
  localparam string c_parity_even = "even";
  localparam string c_parity_odd  = "odd";

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_deframer_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_deframer_if
// Description : Line-side inputs (synchronised RX, start pulse) and the
//               received-byte outputs of the UART RX deframer.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_deframer_if #(
  parameter int DATA_BITS = 8
);

  logic                 rx_i;
  logic                 start_pulse_i;
  logic [DATA_BITS-1:0] data_o;
  logic                 valid_o;
  logic                 parity_err_o;
  logic                 frame_err_o;
  logic                 busy_o;

  // Deframer side: consumes the line, produces the byte and flags
  modport master (
    input  rx_i,
    input  start_pulse_i,
    output data_o,
    output valid_o,
    output parity_err_o,
    output frame_err_o,
    output busy_o
  );

  // Line / host side: drives the line, observes the byte and flags
  modport slave (
    output rx_i,
    output start_pulse_i,
    input  data_o,
    input  valid_o,
    input  parity_err_o,
    input  frame_err_o,
    input  busy_o
  );

endinterface : uart_rx_deframer_if
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_bit_timer
// Description : Down-counting bit timer. Strikes for one cycle when the count
//               reaches zero while enabled, then reloads a full bit period.
//               A half load positions the first strike at mid start bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_half_i,
  input  logic load_full_i,
  input  logic count_en_i,
  output logic strike_o
);

  localparam int            c_cnt_w     = $clog2(CLKS_PER_BIT);
  localparam logic [c_cnt_w-1:0] c_half_load = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_cnt_w-1:0] c_full_load = c_cnt_w'(CLKS_PER_BIT - 1);

  logic [c_cnt_w-1:0] r_cnt;

  assign strike_o = count_en_i && (r_cnt == '0);

  // Count down while enabled; explicit loads win, a strike reloads a full bit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (load_half_i) begin
      r_cnt <= c_half_load;
    end else if (load_full_i || strike_o) begin
      r_cnt <= c_full_load;
    end else if (count_en_i) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule : uart_bit_timer
`default_nettype wire

// File: rtl/uart_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_deframer
// Description : UART receive frame engine. Accepts the start pulse from the
//               falling-edge detector, samples the line at mid-bit, assembles
//               the byte LSB-first and strobes it out with parity and framing
//               error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int    CLKS_PER_BIT = 434,
  parameter int    DATA_BITS    = 8,
  parameter string PARITY       = "none"
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  uart_rx_deframer_if.master     bus
);

  localparam bit         c_par_en  = (PARITY != c_parity_none);
  localparam bit         c_par_odd = (PARITY == c_parity_odd);
  localparam logic [3:0] c_last_idx = 4'(DATA_BITS - 1);

  if (!((PARITY == c_parity_none) || (PARITY == c_parity_even) ||
        (PARITY == c_parity_odd))) begin : g_bad_parity
    $error("uart_rx_deframer: PARITY must be \"none\", \"even\" or \"odd\"");
  end

  uart_state_e          r_state;
  uart_state_e          w_state_next;
  logic                 w_strike;
  logic                 w_count_en;
  logic                 w_load_half;
  logic                 w_clr_idx;
  logic                 w_shift;
  logic                 w_par_capture;
  logic                 w_done;

  logic [3:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_parity_err;
  logic                 r_frame_err;

  assign w_count_en = (r_state != S_IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_half_i (w_load_half),
    .load_full_i (1'b0),
    .count_en_i  (w_count_en),
    .strike_o    (w_strike)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and per-sample datapath controls
  always_comb begin
    w_state_next  = r_state;
    w_load_half   = 1'b0;
    w_clr_idx     = 1'b0;
    w_shift       = 1'b0;
    w_par_capture = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start_pulse_i) begin
          w_load_half  = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_strike) begin
          // Line back high at mid start bit means the edge was a glitch
          if (bus.rx_i) begin
            w_state_next = S_IDLE;
          end else begin
            w_clr_idx    = 1'b1;
            w_state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_strike) begin
          w_shift = 1'b1;
          if (r_bit_idx == c_last_idx) begin
            w_state_next = c_par_en ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (w_strike) begin
          w_par_capture = 1'b1;
          w_state_next  = S_STOP;
        end
      end
      S_STOP: begin
        // Leave at mid stop bit so a following start edge is not missed
        if (w_strike) begin
          w_done       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Shift register, bit index, parity check and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_par_err    <= 1'b0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_valid <= w_done;
      if (w_clr_idx) begin
        r_bit_idx <= '0;
        r_par_err <= 1'b0;
      end
      if (w_shift) begin
        r_shift   <= {bus.rx_i, r_shift[DATA_BITS-1:1]};
        r_bit_idx <= r_bit_idx + 4'd1;
      end
      if (w_par_capture) begin
        r_par_err <= (^r_shift) ^ bus.rx_i ^ c_par_odd;
      end
      if (w_done) begin
        r_data       <= r_shift;
        r_parity_err <= r_par_err;
        r_frame_err  <= ~bus.rx_i;
      end
    end
  end

  assign bus.data_o       = r_data;
  assign bus.valid_o      = r_valid;
  assign bus.parity_err_o = r_parity_err;
  assign bus.frame_err_o  = r_frame_err;
  assign bus.busy_o       = (r_state != S_IDLE);

endmodule : uart_rx_deframer
`default_nettype wire
